// File: rtl/uart_tx_controller.sv
`timescale 1ns/1ps
// UART transmitter: frames one byte as start + 8 data (LSB first) + parity + stop,
// advancing one bit every OVERSAMPLE sample_ENABLE ticks.
module uart_tx_controller #(
   parameter int OVERSAMPLE  = 16,
   parameter bit PARITY_EVEN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_ENABLE,
   input  logic       Tx_EN,
   input  logic       Tx_WR,
   input  logic [7:0] Tx_DATA,
   output logic       TxD,
   output logic       Tx_BUSY,
   output logic       Tx_DONE
);

   localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]        state;
   logic [TICK_W-1:0] tick_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        data_latch;
   logic              parity_bit;
   logic              bit_end;

   // The OVERSAMPLE-th tick of a bit both wraps the tick counter and closes the bit.
   assign bit_end = sample_ENABLE && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         bit_idx    <= '0;
         data_latch <= '0;
         parity_bit <= 1'b0;
         TxD        <= 1'b1;
         Tx_BUSY    <= 1'b0;
         Tx_DONE    <= 1'b0;
      end else begin
         Tx_DONE <= 1'b0;
         if (state == IDLE) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            if (Tx_EN && Tx_WR) begin
               data_latch <= Tx_DATA;
               parity_bit <= PARITY_EVEN ? (^Tx_DATA) : (~^Tx_DATA);
               state      <= START;
               TxD        <= 1'b0;
               Tx_BUSY    <= 1'b1;
            end
         end else begin
            if (sample_ENABLE) begin
               tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            end
            // Outputs are registered, so each transition loads the level of the next bit.
            if (bit_end) begin
               case (state)
                  START: begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                     TxD     <= data_latch[0];
                  end
                  DATA: begin
                     if (bit_idx == 3'd7) begin
                        state <= PARITY;
                        TxD   <= parity_bit;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                        TxD     <= data_latch[bit_idx + 3'd1];
                     end
                  end
                  PARITY: begin
                     state <= STOP;
                     TxD   <= 1'b1;
                  end
                  STOP: begin
                     state   <= IDLE;
                     TxD     <= 1'b1;
                     Tx_BUSY <= 1'b0;
                     Tx_DONE <= 1'b1;
                  end
                  default: begin
                     state   <= IDLE;
                     TxD     <= 1'b1;
                     Tx_BUSY <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: doc/uart_tx_controller.md
UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, number of sample_ENABLE pulses per serial bit.
REQ-002 Parameter: PARITY_EVEN, default 1; 1 = even parity, 0 = odd parity.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sample_ENABLE  input  1  one-clk-wide tick from the baud generator, OVERSAMPLE ticks per bit.
REQ-006 Tx_EN  input  1  transmitter enable; gates acceptance of new frames.
REQ-007 Tx_WR  input  1  write strobe; requests transmission of Tx_DATA.
REQ-008 Tx_DATA  input  8  byte to transmit, sampled only on acceptance.
REQ-009 TxD  output  1  serial line, idle high.
REQ-010 Tx_BUSY  output  1  high while a frame is in progress.
REQ-011 Tx_DONE  output  1  one-clk pulse when a frame's stop bit completes.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; TxD and Tx_BUSY SHALL be registered outputs.
REQ-013 Acceptance: in IDLE with Tx_EN=1 and Tx_WR=1 at a rising edge, the block SHALL latch Tx_DATA, compute parity, clear the tick and bit counters, and enter START.
REQ-014 Latency: TxD=0 and Tx_BUSY=1 SHALL be visible the cycle after the accepting edge.
REQ-015 Tx_WR with Tx_EN=0, or Tx_WR while Tx_BUSY=1, SHALL be ignored with no side effect; the latched byte SHALL not change.
REQ-016 Tick counter: width ceil(log2(OVERSAMPLE)) bits; it SHALL increment only on sample_ENABLE and SHALL wrap to 0 on the OVERSAMPLE-th tick of each bit, and that tick SHALL end the current bit.
REQ-017 START: TxD=0 for one bit, then go to DATA with bit index 0.
REQ-018 DATA: TxD = latched byte bit[index], LSB first; index 0..7 (3-bit); after bit 7 go to PARITY.
REQ-019 PARITY: TxD = XOR of the 8 latched bits when PARITY_EVEN=1, its complement when 0; then go to STOP.
REQ-020 STOP: TxD=1 for one bit; on its final tick go to IDLE, with Tx_DONE=1 and Tx_BUSY=0 in the following cycle.
REQ-021 Tx_DONE SHALL be high for exactly one clk per completed frame.
REQ-022 Tx_WR on the same edge as the final stop tick SHALL be ignored, because Tx_BUSY is still 1; a new frame is accepted on any later edge.
REQ-023 Back-to-back frames: the earliest accept is the cycle Tx_DONE=1; the frame gap is then one clk of TxD=1 beyond the stop bit.
REQ-024 Tx_EN deasserted mid-frame SHALL NOT abort the frame; the frame completes normally.
REQ-025 sample_ENABLE in IDLE SHALL be ignored, and the counters SHALL hold at 0.
REQ-026 A frame SHALL be 11 bits: 1 start, 8 data, 1 parity, 1 stop; total duration 11*OVERSAMPLE sample_ENABLE ticks from acceptance.

Reset
REQ-027 On reset=1 at a rising edge: state=IDLE, TxD=1, Tx_BUSY=0, Tx_DONE=0, counters=0, latched byte=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately, with TxD=1 the next cycle and no Tx_DONE pulse.
REQ-029 Reset SHALL take priority over Tx_WR on the same edge; the write SHALL be lost.

Verification
REQ-030 Basic frame: sample_ENABLE every 4 clk, Tx_EN=1, Tx_WR pulse with Tx_DATA=0xA5 -> TxD sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 64 clk; Tx_BUSY high for 704 clk; one Tx_DONE pulse.
REQ-031 Odd parity: PARITY_EVEN=0, Tx_DATA=0x01 -> parity bit=0; with PARITY_EVEN=1, same data -> parity bit=1.
REQ-032 Ignored writes: Tx_WR with Tx_DATA=0xFF during a 0x3C frame -> 0x3C is transmitted unaltered; Tx_WR with Tx_EN=0 in IDLE -> TxD stays 1 and Tx_BUSY stays 0.
REQ-033 Back-to-back: Tx_WR held high with 0x55, then 0xAA on the Tx_DONE cycle -> two frames, with an inter-frame idle of 1 clk beyond the stop bit.
REQ-034 Reset mid-frame: reset pulse during data bit 3 of 0x0F -> TxD=1, Tx_BUSY=0 the next cycle, no Tx_DONE; a new 0x81 frame then transmits correctly.
REQ-035 Collision: Tx_WR coincident with the final stop tick -> ignored; Tx_WR coincident with reset -> no frame.
